wave_pwm_dac: RTL
=================

Name: wave_pwm_dac

Overview:
- Output stage directly downstream of the digital function generator.
- Accepts unsigned 8-bit waveform samples through a valid/ready handshake and applies a centred gain (signed around midscale 128).
- Clamps the scaled result and drives a single-bit PWM pin for the board's RC low-pass DAC.
- Emits one new duty value per PWM period and reports underrun and clipping.

Parameters:
- PRESC_W, 8, width of the prescale input and prescaler counter.
- RESET_DUTY, 128, duty value loaded on reset (midscale, 50 %).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; 0 freezes and clears the PWM engine
- prescale  in  PRESC_W  PWM counter advances once every prescale+1 clocks
- gain  in  4  amplitude in 1/8 steps (8 = unity, 0 = flat midscale, 15 = x1.875)
- sample_in  in  8  unsigned sample from the generator
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  one-entry buffer is empty
- pwm_out  out  1  PWM pin, registered
- duty  out  8  duty value currently in use
- period_tick  out  1  one-cycle pulse at each PWM period start
- underrun  out  1  one-cycle pulse when a period starts with no sample pending
- clip  out  1  one-cycle pulse when a loaded duty was clamped

Behaviour:
- Reset (async, rst=1): presc_cnt=0, pwm_cnt=0, pend_valid=0, duty=RESET_DUTY, pwm_out=0, period_tick=0, underrun=0, clip=0.
  - sample_ready=1 as soon as rst releases (sample_ready = ~pend_valid).
- Handshake:
  - Transfer occurs when sample_valid && sample_ready at a rising edge.
  - sample_in is stored in pend; pend_valid is set on the next edge.
  - Inputs are ignored while sample_ready=0; the upstream stage holds or drops samples.
- Prescaler:
  - tick = en && (presc_cnt == prescale).
  - On tick, presc_cnt goes to 0; otherwise presc_cnt increments.
  - prescale=0 gives tick every clock.
  - A prescale change mid-count: if presc_cnt already exceeds the new value, the counter wraps through 2^PRESC_W; no special handling.
- PWM counter:
  - pwm_cnt increments by 1 on tick and wraps 255 -> 0.
  - Period boundary = tick && pwm_cnt==255.
  - Period length = 256*(prescale+1) clocks.
- Period boundary, same edge:
  - period_tick=1.
  - If pend_valid: duty <= scaled(pend), pend_valid <= 0, clip <= clamp_occurred.
  - Else: duty holds, underrun <= 1.
  - A transfer cannot coincide with a load, because ready=0 whenever pend_valid=1.
- Scaling (combinational into the duty register):
  - s = sample - 128, 9-bit signed.
  - p = s * gain, 13-bit signed.
  - q = (p >>> 3) + 128, arithmetic shift, truncating toward -inf.
  - duty = clamp(q, 0, 255); clip asserted if q<0 or q>255.
- pwm_out:
  - Registered each clock as en && (pwm_cnt < duty), using the pre-edge values, so it lags pwm_cnt by one clock.
  - duty=0 gives constant low; duty=255 gives high for 255 of 256 counts.
- en=0:
  - presc_cnt and pwm_cnt are cleared to 0 on the next edge; pwm_out=0.
  - No ticks, period_tick, or underrun.
  - The handshake still works: one sample may be buffered, and duty holds.
  - When en rises, the counters start from 0; the first boundary comes after a full period.
- Pulse outputs (period_tick, underrun, clip) are high for exactly one clock and 0 otherwise.
- Reset mid-period: everything returns to reset values immediately; any buffered sample is discarded.

Test Plan:
- Reset release, en=1, prescale=0, no samples -> pwm_out high for 128 of every 256 clocks; period_tick every 256 clocks; underrun pulses with each period_tick; duty stays 128.
- gain=8, sample_in=200 presented before a boundary -> sample_ready drops the clock after the transfer; at the boundary duty=200 and sample_ready=1 again; next period pwm_out high 200 clocks, clip=0.
- gain=4, sample 200 -> duty=164; gain=15, sample 255 -> duty=255 with clip pulse; gain=15, sample 0 -> duty=0 with clip pulse and pwm_out constantly low; gain=0, any sample -> duty=128.
- prescale=3, gain=8, sample 64 -> period length 1024 clocks; pwm_out high 256 clocks per period; period_tick spacing 1024.
- sample_valid held high with changing data 10,20,30 each clock -> only the first value is accepted per period; ready stays low until the boundary; duty sequence 10, then the value present when ready next rises.
- en dropped mid-period -> pwm_out=0 and counters=0 next clock, no period_tick; rst asserted while pend_valid=1 -> duty=128, sample_ready=1, buffered sample lost.

Source files
------------

// File: rtl/wave_pwm_dac.sv
// rtl/wave_pwm_dac.sv - gain/clamp stage and single-bit PWM driver for the RC low-pass DAC
module wave_pwm_dac #(
    parameter int         PRESC_W    = 8,
    parameter logic [7:0] RESET_DUTY = 8'd128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [3:0]         gain,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               pwm_out,
    output logic [7:0]         duty,
    output logic               period_tick,
    output logic               underrun,
    output logic               clip
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [7:0]         pwm_cnt;
    logic [7:0]         pend;
    logic               pend_valid;

    logic               tick;
    logic               boundary;
    logic signed [8:0]  s_val;
    logic signed [12:0] p_val;
    logic signed [12:0] q_val;
    logic [7:0]         scaled;
    logic               clamped;

    // The buffer is a single slot, so ready is simply "slot empty".
    assign sample_ready = ~pend_valid;
    assign tick         = en && (presc_cnt == prescale);
    assign boundary     = tick && (pwm_cnt == 8'd255);

    // Centred gain: offset around midscale, scale in 1/8 steps, re-centre and clamp.
    always_comb begin
        s_val   = $signed({1'b0, pend} - 9'd128);
        p_val   = $signed({{4{s_val[8]}}, s_val}) * $signed({9'd0, gain});
        q_val   = (p_val >>> 3) + 13'sd128;
        scaled  = q_val[7:0];
        clamped = 1'b0;
        if (q_val < 13'sd0) begin
            scaled  = 8'd0;
            clamped = 1'b1;
        end else if (q_val > 13'sd255) begin
            scaled  = 8'd255;
            clamped = 1'b1;
        end
    end

    // Prescaler and PWM counters; both held at zero while disabled so a re-enable starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= 8'd0;
        end else if (!en) begin
            presc_cnt <= '0;
            pwm_cnt   <= 8'd0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 8'd1;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // Sample buffer, duty load at period boundaries, status pulses and the registered PWM pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 8'd0;
            pend_valid  <= 1'b0;
            duty        <= RESET_DUTY;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            underrun    <= 1'b0;
            clip        <= 1'b0;
        end else begin
            period_tick <= boundary;
            underrun    <= boundary && !pend_valid;
            clip        <= boundary && pend_valid && clamped;
            pwm_out     <= en && (pwm_cnt < duty);
            if (boundary && pend_valid) begin
                duty       <= scaled;
                pend_valid <= 1'b0;
            end else if (sample_valid && !pend_valid) begin
                pend       <= sample_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
